fp_addsub_param: RTL and testbench

- Parametrised multicycle floating-point add/subtract/convert unit for the RISC5-class CPU; successor to the fixed 32-bit adder.
- Performs ADD, SUB, FLT (signed int to float) and FLOOR (float to signed int) over configurable exponent/fraction widths.
- Adds round-to-nearest-even, IEEE-style specials and exception flags.
- Sits beside the multiplier/divider on the ALU result mux and uses the same run/stall handshake with the CPU pipeline.

---
 rtl/fp_pkg.sv | 32 +++
 rtl/fp_addsub_param_if.sv | 23 ++
 rtl/fp_norm_shift.sv | 24 ++
 rtl/fp_addsub_param.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_fp_addsub_param.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared encodings and width helpers for the parametrised FP add/sub unit
package fp_pkg;

  // operation select
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_FLT   = 2'b10;
  localparam logic [1:0] OP_FLOOR = 2'b11;

  // bit positions inside flags = {inv, ovf, unf, inx}
  localparam int F_INV = 3;
  localparam int F_OVF = 2;
  localparam int F_UNF = 1;
  localparam int F_INX = 0;

  // FSM state encoding
  localparam logic [1:0] ST_ALIGN = 2'd0;
  localparam logic [1:0] ST_SUM   = 2'd1;
  localparam logic [1:0] ST_NORM  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // packed word width: sign + exponent + stored fraction
  function automatic int fp_width(input int ew, input int mw);
    return 1 + ew + mw;
  endfunction

  // internal sum width: carry + hidden bit + fraction + guard/round/sticky
  function automatic int fp_sum_width(input int mw);
    return mw + 5;
  endfunction

endpackage

// File: rtl/fp_addsub_param_if.sv
// rtl/fp_addsub_param_if.sv - run/stall handshake and operand/result bundle for the FP unit
interface fp_addsub_param_if
  import fp_pkg::*;
#(
  parameter int EW = 8,
  parameter int MW = 23
);
  localparam int W = fp_width(EW, MW);

  logic         run;
  logic [1:0]   op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         stall;
  logic [W-1:0] z;
  logic [3:0]   flags;

  // CPU pipeline side
  modport master (output run, op, x, y, input stall, z, flags);
  // arithmetic unit side
  modport slave (input run, op, x, y, output stall, z, flags);

endinterface

// File: rtl/fp_norm_shift.sv
// rtl/fp_norm_shift.sv - leading-zero counter plus left shifter for normalisation
module fp_norm_shift #(
  parameter int NW = 32,
  parameter int CW = $clog2(NW + 1)
) (
  input  logic [NW-1:0] din,
  output logic [NW-1:0] dout,
  output logic [CW-1:0] cnt
);

  // leading-zero count; an all-zero input reports NW
  always_comb begin
    cnt = CW'(NW);
    for (int i = 0; i < NW; i++) begin
      if (din[i]) cnt = CW'(NW - 1 - i);
    end
  end

  // shift the leading one up to the MSB
  always_comb begin
    dout = din << cnt;
  end

endmodule

// File: rtl/fp_addsub_param.sv
// rtl/fp_addsub_param.sv - multicycle FP add/sub/int-to-float/floor unit with RNE rounding
module fp_addsub_param
  import fp_pkg::*;
#(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic              clk,
  input  logic              rst,
  fp_addsub_param_if.slave  bus
);

  localparam int W    = fp_width(EW, MW);
  localparam int SW   = fp_sum_width(MW);
  localparam int AW   = MW + 4;
  localparam int XW   = EW + $clog2(W) + 3;
  localparam int CW   = $clog2(W + 1);
  localparam int SHW  = $clog2(W);
  localparam int BIAS = (1 << (EW - 1)) - 1;

  localparam logic [EW-1:0] EXP_MAX = '1;
  localparam logic [W-1:0]  QNAN    = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
  localparam logic [W-1:0]  INT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  INT_MIN = {1'b1, {(W-1){1'b0}}};

  // registered state
  logic [1:0]           state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic                 sign_q, sign_d;
  logic                 sub_q, sub_d;
  logic                 zsign_q, zsign_d;
  logic [EW-1:0]        exp_q, exp_d;
  logic [AW-1:0]        ma_q, ma_d;
  logic [AW-1:0]        mb_q, mb_d;
  logic [W-1:0]         xr_q, xr_d;
  logic                 dir_valid_q, dir_valid_d;
  logic [W-1:0]         dir_z_q, dir_z_d;
  logic [3:0]           dir_flags_q, dir_flags_d;
  logic [W-1:0]         nin_q, nin_d;
  logic signed [XW-1:0] base_q, base_d;
  logic                 rsign_q, rsign_d;
  logic [W-1:0]         z_q, z_d;
  logic [3:0]           flags_q, flags_d;

  // align-stage signals
  logic          sx, sy;
  logic [EW-1:0] ex, ey;
  logic [MW-1:0] fx, fy;
  logic          x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  logic [MW:0]   man_x, man_y;
  logic          x_big;
  logic          big_s;
  logic [EW-1:0] big_e, sml_e, diff;
  logic [MW:0]   big_m, sml_m;
  logic [2*AW-1:0] al_wide;
  logic [AW-1:0] al_raw, al_m;
  logic          al_st;
  logic          sp_valid;
  logic [W-1:0]  sp_z;
  logic [3:0]    sp_flags;

  // sum-stage signals
  logic [SW-1:0]        sum_v;
  logic [W-1:0]         flt_mag;
  logic                 fl_s;
  logic [EW-1:0]        fl_e;
  logic [MW-1:0]        fl_f;
  logic signed [XW-1:0] fl_ue;
  logic [SHW-1:0]       fl_sh;
  logic [W+MW-1:0]      fl_wide;
  logic [W-1:0]         fl_ip, fl_mag, fl_z;
  logic                 fl_fr;
  logic [3:0]           fl_flags;

  // norm-stage signals
  logic [W-1:0]         nrm;
  logic [CW-1:0]        lz;
  logic                 rnd_g, rnd_st, rnd_lsb, rnd_up, carry;
  logic [MW+1:0]        mant;
  logic [MW-1:0]        frac;
  logic signed [XW-1:0] e_res;
  logic [W-1:0]         nz;
  logic [3:0]           nflags;

  fp_norm_shift #(.NW(W), .CW(CW)) u_norm_shift (
    .din  (nin_q),
    .dout (nrm),
    .cnt  (lz)
  );

  // unpack, classify, order by magnitude and right-align the smaller operand
  always_comb begin
    sx     = bus.x[W-1];
    ex     = bus.x[W-2:MW];
    fx     = bus.x[MW-1:0];
    sy     = bus.y[W-1] ^ (bus.op == OP_SUB);
    ey     = bus.y[W-2:MW];
    fy     = bus.y[MW-1:0];
    x_zero = (ex == '0);
    y_zero = (ey == '0);
    x_inf  = (ex == EXP_MAX) && (fx == '0);
    y_inf  = (ey == EXP_MAX) && (fy == '0);
    x_nan  = (ex == EXP_MAX) && (fx != '0);
    y_nan  = (ey == EXP_MAX) && (fy != '0);
    man_x  = x_zero ? '0 : {1'b1, fx};
    man_y  = y_zero ? '0 : {1'b1, fy};
    x_big  = {ex, man_x} >= {ey, man_y};
    big_s  = x_big ? sx : sy;
    big_e  = x_big ? ex : ey;
    big_m  = x_big ? man_x : man_y;
    sml_e  = x_big ? ey : ex;
    sml_m  = x_big ? man_y : man_x;
    diff   = big_e - sml_e;
    al_wide = {sml_m, 3'b000, {AW{1'b0}}} >> diff;
    if ({{(XW-EW){1'b0}}, diff} > XW'(AW - 1)) begin
      al_raw = '0;
      al_st  = |sml_m;
    end else begin
      al_raw = al_wide[2*AW-1:AW];
      al_st  = |al_wide[AW-1:0];
    end
    al_m = {al_raw[AW-1:1], al_raw[0] | al_st};

    sp_valid = 1'b0;
    sp_z     = '0;
    sp_flags = '0;
    if (x_nan || y_nan || (x_inf && y_inf && (sx != sy))) begin
      sp_valid        = 1'b1;
      sp_z            = QNAN;
      sp_flags[F_INV] = 1'b1;
    end else if (x_inf) begin
      sp_valid = 1'b1;
      sp_z     = {sx, EXP_MAX, {MW{1'b0}}};
    end else if (y_inf) begin
      sp_valid = 1'b1;
      sp_z     = {sy, EXP_MAX, {MW{1'b0}}};
    end
  end

  // magnitude sum, integer magnitude for FLT and the complete FLOOR result
  always_comb begin
    sum_v   = sub_q ? ({1'b0, ma_q} - {1'b0, mb_q}) : ({1'b0, ma_q} + {1'b0, mb_q});
    flt_mag = xr_q[W-1] ? -xr_q : xr_q;

    fl_s    = xr_q[W-1];
    fl_e    = xr_q[W-2:MW];
    fl_f    = xr_q[MW-1:0];
    fl_ue   = $signed(XW'(fl_e)) - $signed(XW'(BIAS));
    fl_sh   = fl_ue[SHW-1:0];
    fl_wide = {{(W-1){1'b0}}, 1'b1, fl_f} << fl_sh;
    fl_ip   = fl_wide[W+MW-1:MW];
    fl_fr   = |fl_wide[MW-1:0];
    fl_mag  = fl_ip + {{(W-1){1'b0}}, fl_s & fl_fr};

    fl_z     = '0;
    fl_flags = '0;
    if (fl_e == EXP_MAX) begin
      fl_flags[F_INV] = 1'b1;
      fl_z            = ((fl_f != '0) || !fl_s) ? INT_MAX : INT_MIN;
    end else if (fl_e == '0) begin
      fl_z = '0;
    end else if (fl_ue[XW-1]) begin
      fl_z            = fl_s ? '1 : '0;
      fl_flags[F_INX] = 1'b1;
    end else if (fl_ue >= $signed(XW'(W - 1))) begin
      if (fl_s && (fl_ue == $signed(XW'(W - 1))) && (fl_f == '0)) begin
        fl_z = INT_MIN;
      end else begin
        fl_z            = fl_s ? INT_MIN : INT_MAX;
        fl_flags[F_INV] = 1'b1;
      end
    end else begin
      fl_z            = fl_s ? -fl_mag : fl_mag;
      fl_flags[F_INX] = fl_fr;
    end
  end

  // round-to-nearest-even on the normalised value and pack with range checks
  always_comb begin
    rnd_g   = nrm[EW-1];
    rnd_st  = |nrm[EW-2:0];
    rnd_lsb = nrm[EW];
    rnd_up  = rnd_g & (rnd_st | rnd_lsb);
    mant    = {1'b0, nrm[W-1:EW]} + {{(MW+1){1'b0}}, rnd_up};
    carry   = mant[MW+1];
    frac    = carry ? mant[MW:1] : mant[MW-1:0];
    e_res   = base_q - $signed(XW'(lz)) + $signed(XW'(carry));

    nz     = '0;
    nflags = '0;
    if (dir_valid_q) begin
      nz     = dir_z_q;
      nflags = dir_flags_q;
    end else if (nin_q == '0) begin
      nz = {zsign_q, {(W-1){1'b0}}};
    end else if (e_res > $signed(XW'((1 << EW) - 2))) begin
      nz            = {rsign_q, EXP_MAX, {MW{1'b0}}};
      nflags[F_OVF] = 1'b1;
      nflags[F_INX] = 1'b1;
    end else if (e_res < $signed(XW'(1))) begin
      nz            = {rsign_q, {(W-1){1'b0}}};
      nflags[F_UNF] = 1'b1;
      nflags[F_INX] = 1'b1;
    end else begin
      nz            = {rsign_q, e_res[EW-1:0], frac};
      nflags[F_INX] = rnd_g | rnd_st;
    end
  end

  // FSM sequencing and per-stage register updates; dropping run aborts to ALIGN
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sign_d      = sign_q;
    sub_d       = sub_q;
    zsign_d     = zsign_q;
    exp_d       = exp_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    xr_d        = xr_q;
    dir_valid_d = dir_valid_q;
    dir_z_d     = dir_z_q;
    dir_flags_d = dir_flags_q;
    nin_d       = nin_q;
    base_d      = base_q;
    rsign_d     = rsign_q;
    z_d         = z_q;
    flags_d     = flags_q;
    case (state_q)
      ST_ALIGN: begin
        if (bus.run) begin
          op_d        = bus.op;
          xr_d        = bus.x;
          sign_d      = big_s;
          sub_d       = (sx != sy);
          zsign_d     = sx & sy;
          exp_d       = big_e;
          ma_d        = {big_m, 3'b000};
          mb_d        = al_m;
          dir_valid_d = sp_valid && ((bus.op == OP_ADD) || (bus.op == OP_SUB));
          dir_z_d     = sp_z;
          dir_flags_d = sp_flags;
          state_d     = ST_SUM;
        end
      end
      ST_SUM: begin
        if (!bus.run) begin
          state_d = ST_ALIGN;
        end else begin
          if (op_q == OP_FLT) begin
            nin_d   = flt_mag;
            base_d  = $signed(XW'(BIAS + W - 1));
            rsign_d = xr_q[W-1];
            zsign_d = 1'b0;
          end else if (op_q == OP_FLOOR) begin
            dir_valid_d = 1'b1;
            dir_z_d     = fl_z;
            dir_flags_d = fl_flags;
          end else begin
            nin_d   = W'(sum_v) << (W - SW);
            base_d  = $signed(XW'(exp_q) + XW'(1));
            rsign_d = sign_q;
          end
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        if (!bus.run) begin
          state_d = ST_ALIGN;
        end else begin
          z_d     = nz;
          flags_d = nflags;
          state_d = ST_DONE;
        end
      end
      default: begin
        if (!bus.run) state_d = ST_ALIGN;
      end
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ALIGN;
      op_q        <= '0;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      zsign_q     <= 1'b0;
      exp_q       <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      xr_q        <= '0;
      dir_valid_q <= 1'b0;
      dir_z_q     <= '0;
      dir_flags_q <= '0;
      nin_q       <= '0;
      base_q      <= '0;
      rsign_q     <= 1'b0;
      z_q         <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sign_q      <= sign_d;
      sub_q       <= sub_d;
      zsign_q     <= zsign_d;
      exp_q       <= exp_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      xr_q        <= xr_d;
      dir_valid_q <= dir_valid_d;
      dir_z_q     <= dir_z_d;
      dir_flags_q <= dir_flags_d;
      nin_q       <= nin_d;
      base_q      <= base_d;
      rsign_q     <= rsign_d;
      z_q         <= z_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.stall = bus.run & (state_q != ST_DONE);
  assign bus.z     = z_q;
  assign bus.flags = flags_q;

endmodule

// File: tb/tb_fp_addsub_param.sv
// tb/tb_fp_addsub_param.sv - directed self-checking bench for fp_addsub_param
module tb_fp_addsub_param;
  import fp_pkg::*;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   n;

  fp_addsub_param_if #(.EW(8), .MW(23)) bus_if ();

  fp_addsub_param #(.EW(8), .MW(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ez, input logic [3:0] ef);
    int k;
    @(negedge clk);
    bus_if.run = 1'b1;
    bus_if.op  = o;
    bus_if.x   = a;
    bus_if.y   = b;
    #1;
    k = 0;
    while (bus_if.stall && k < 20) begin
      k++;
      @(negedge clk);
    end
    chk({tag, " stall_cycles"}, 64'(k), 64'd3);
    chk({tag, " z"}, 64'(bus_if.z), 64'(ez));
    chk({tag, " flags"}, 64'(bus_if.flags), 64'(ef));
    bus_if.run = 1'b0;
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    bus_if.run = 1'b0;
    bus_if.op  = OP_ADD;
    bus_if.x   = '0;
    bus_if.y   = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset z", 64'(bus_if.z), 64'h0);
    chk("reset flags", 64'(bus_if.flags), 64'h0);
    chk("reset stall", 64'(bus_if.stall), 64'h0);

    run_op("add 1+2", OP_ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000);
    run_op("tie even", OP_ADD, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0001);
    run_op("tie odd", OP_ADD, 32'h3F800001, 32'h33800000, 32'h3F800002, 4'b0001);

    // abort in SUM: result registers must hold the tie-odd result
    @(negedge clk);
    bus_if.run = 1'b1;
    bus_if.op  = OP_ADD;
    bus_if.x   = 32'h40000000;
    bus_if.y   = 32'h40000000;
    #1;
    @(negedge clk);
    bus_if.run = 1'b0;
    @(negedge clk);
    chk("abort z", 64'(bus_if.z), 64'h3F800002);
    chk("abort flags", 64'(bus_if.flags), 64'h1);
    chk("abort stall", 64'(bus_if.stall), 64'h0);

    run_op("sub cancel", OP_SUB, 32'h40490FDB, 32'h40490FDB, 32'h00000000, 4'b0000);
    run_op("neg zeros", OP_ADD, 32'h80000000, 32'h80000000, 32'h80000000, 4'b0000);
    run_op("overflow", OP_ADD, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101);
    run_op("underflow", OP_SUB, 32'h00800001, 32'h00800000, 32'h00000000, 4'b0011);
    run_op("inf-inf", OP_ADD, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000);
    run_op("nan+1", OP_ADD, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000);
    run_op("inf+1", OP_ADD, 32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b0000);
    run_op("flt 7", OP_FLT, 32'h00000007, 32'h0, 32'h40E00000, 4'b0000);
    run_op("flt 2^24+1", OP_FLT, 32'h01000001, 32'h0, 32'h4B800000, 4'b0001);
    run_op("flt -1", OP_FLT, 32'hFFFFFFFF, 32'h0, 32'hBF800000, 4'b0000);
    run_op("flt 0", OP_FLT, 32'h00000000, 32'h0, 32'h00000000, 4'b0000);
    run_op("floor -2.5", OP_FLOOR, 32'hC0200000, 32'h0, 32'hFFFFFFFD, 4'b0001);
    run_op("floor -2^31", OP_FLOOR, 32'hCF000000, 32'h0, 32'h80000000, 4'b0000);
    run_op("floor 2^31", OP_FLOOR, 32'h4F000000, 32'h0, 32'h7FFFFFFF, 4'b1000);

    // operands change after ALIGN: result must use the sampled values
    @(negedge clk);
    bus_if.run = 1'b1;
    bus_if.op  = OP_ADD;
    bus_if.x   = 32'h3F800000;
    bus_if.y   = 32'h40000000;
    #1;
    @(negedge clk);
    bus_if.op = OP_SUB;
    bus_if.x  = 32'h42000000;
    bus_if.y  = 32'h00000000;
    n = 1;
    while (bus_if.stall && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("late input stall_cycles", 64'(n), 64'd3);
    chk("late input z", 64'(bus_if.z), 64'h40400000);
    bus_if.run = 1'b0;

    run_op("floor 2^31 again", OP_FLOOR, 32'h4F000000, 32'h0, 32'h7FFFFFFF, 4'b1000);

    // reset while in NORM with run held, then the op completes from ALIGN
    @(negedge clk);
    bus_if.run = 1'b1;
    bus_if.op  = OP_ADD;
    bus_if.x   = 32'h3F800000;
    bus_if.y   = 32'h3F800000;
    #1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst norm z", 64'(bus_if.z), 64'h0);
    chk("rst norm flags", 64'(bus_if.flags), 64'h0);
    chk("rst norm stall", 64'(bus_if.stall), 64'h1);
    rst = 1'b0;
    n = 0;
    while (bus_if.stall && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("reissue stall_cycles", 64'(n), 64'd3);
    chk("reissue z", 64'(bus_if.z), 64'h40000000);
    chk("reissue flags", 64'(bus_if.flags), 64'h0);
    bus_if.run = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
